// File: rtl/fifo_unpack_pkg.sv
// Shared types and constants for the fifo_unpack word-to-beat serializer.
package fifo_unpack_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int WORD_COUNT_W = 16;

endpackage

// File: rtl/fifo_unpack.sv
// Dequeues width-bit words from a FIFO2 and emits them as beat_width-bit beats
// over a valid/ready interface. Define FIFO_UNPACK_MSB_FIRST_EN to emit MSB beat first.
module fifo_unpack
  import fifo_unpack_pkg::*;
#(
  parameter int width      = 32,
  parameter int beat_width = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    FIFO_EMPTY_N,
  input  logic [width-1:0]        FIFO_D_OUT,
  output logic                    FIFO_DEQ,
  input  logic                    CLR,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [beat_width-1:0]   OUT_DATA,
  output logic                    OUT_LAST,
  output logic [WORD_COUNT_W-1:0] WORD_COUNT
);

  localparam int BEATS = width / beat_width;
  localparam int IDX_W = $clog2(BEATS);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [IDX_W-1:0]        r_idx;
  logic [width-1:0]        r_hold;
  logic [beat_width-1:0]   r_last_data;
  logic [WORD_COUNT_W-1:0] r_word_count;

  logic                    w_valid;
  logic                    w_xfer;
  logic                    w_last;
  logic                    w_last_xfer;
  logic                    w_deq;
  int unsigned             w_off;
  logic [beat_width-1:0]   w_beat;

  always_comb begin
    w_off = 32'(r_idx) * beat_width;
`ifdef FIFO_UNPACK_MSB_FIRST_EN
    w_beat = r_hold[width-1-w_off -: beat_width];
`else
    w_beat = r_hold[w_off +: beat_width];
`endif
  end

  assign w_valid     = (r_state == SHIFT);
  assign w_last      = (r_idx == IDX_W'(BEATS - 1));
  assign w_xfer      = w_valid & OUT_READY;
  assign w_last_xfer = w_xfer & w_last;

  // Dequeue either from IDLE or on the final beat, so consecutive words run without a bubble.
  always_comb begin
    w_deq = 1'b0;
    if (!RST && FIFO_EMPTY_N && !CLR)
      w_deq = (r_state == IDLE) | w_last_xfer;
  end

  always_comb begin
    w_next_state = r_state;
    if (CLR) begin
      w_next_state = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (w_deq) w_next_state = SHIFT;
        SHIFT:   if (w_last_xfer) w_next_state = w_deq ? SHIFT : IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_hold       <= '0;
      r_last_data  <= '0;
      r_word_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_deq) begin
        r_hold <= FIFO_D_OUT;
        r_idx  <= '0;
      end else if (CLR) begin
        r_hold <= '0;
        r_idx  <= '0;
      end else if (w_xfer) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_valid)
        r_last_data <= w_beat;
      // A final-beat transfer still counts even when CLR arrives in the same cycle.
      if (w_last_xfer)
        r_word_count <= r_word_count + 1'b1;
    end
  end

  assign FIFO_DEQ   = w_deq;
  assign OUT_VALID  = w_valid;
  assign OUT_DATA   = w_valid ? w_beat : r_last_data;
  assign OUT_LAST   = w_valid & w_last;
  assign WORD_COUNT = r_word_count;

endmodule

// File: doc/fifo_unpack.md
FIFO_UNPACK -- requirements
Module: fifo_unpack

Interface
REQ-001 SHALL have parameter width, default 32: bits per word dequeued from the upstream FIFO2.
REQ-002 SHALL have parameter beat_width, default 8: bits per output beat; width SHALL be an integer multiple of beat_width, with beats = width/beat_width >= 2.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-005 SHALL have port FIFO_EMPTY_N  input  1  upstream FIFO holds at least one word.
REQ-006 SHALL have port FIFO_D_OUT  input  width  upstream FIFO head word.
REQ-007 SHALL have port FIFO_DEQ  output  1  dequeue strobe to upstream FIFO.
REQ-008 SHALL have port CLR  input  1  abort the current word and return to IDLE.
REQ-009 SHALL have port OUT_VALID  output  1  OUT_DATA is valid.
REQ-010 SHALL have port OUT_READY  input  1  downstream accepts the beat.
REQ-011 SHALL have port OUT_DATA  output  beat_width  current beat.
REQ-012 SHALL have port OUT_LAST  output  1  current beat is the final beat of its word.
REQ-013 SHALL have port WORD_COUNT  output  16  count of fully emitted words.

Function
REQ-014 SHALL implement FSM states IDLE and SHIFT; beat index counter of clog2(beats) bits; holding register of width bits.
REQ-015 IDLE: FIFO_DEQ SHALL equal FIFO_EMPTY_N & ~CLR (combinational); on DEQ, SHALL load FIFO_D_OUT, reset beat index to 0, and go to SHIFT next cycle.
REQ-016 SHIFT: OUT_VALID SHALL be 1; OUT_DATA SHALL be the beat selected by beat index; OUT_LAST SHALL be 1 iff beat index = beats-1.
REQ-017 Transfer SHALL occur only on an edge with OUT_VALID & OUT_READY; the beat index SHALL then increment.
REQ-018 OUT_DATA and OUT_LAST SHALL remain stable while OUT_VALID=1 and OUT_READY=0.
REQ-019 On transfer of the last beat, WORD_COUNT SHALL increment, wrapping 0xFFFF -> 0x0000.
REQ-020 On transfer of the last beat with FIFO_EMPTY_N=1 and CLR=0, FIFO_DEQ SHALL assert in that same cycle, reload the register, and stay in SHIFT; this gives zero bubble between words.
REQ-021 On transfer of the last beat with FIFO_EMPTY_N=0, the block SHALL go to IDLE.
REQ-022 Latency SHALL be: first beat valid one cycle after the FIFO_DEQ cycle; sustained throughput one beat per cycle.
REQ-023 FIFO_DEQ SHALL never assert outside REQ-015/REQ-020, nor while FIFO_EMPTY_N=0.
REQ-024 CLR=1 (any state) SHALL force IDLE next cycle, suppress FIFO_DEQ that cycle, discard the held word, and leave WORD_COUNT unchanged. A last-beat transfer coincident with CLR SHALL still count.
REQ-025 In IDLE, OUT_VALID and OUT_LAST SHALL be 0; OUT_DATA SHALL hold its last value.

Reset
REQ-026 RST=1 at a rising edge SHALL set state IDLE, beat index 0, holding register 0, and WORD_COUNT 0; OUT_VALID, OUT_LAST, and OUT_DATA SHALL be 0.
REQ-027 While RST=1, FIFO_DEQ SHALL be 0. Reset mid-word SHALL drop the word without counting it.

Configuration
REQ-028 Macro FIFO_UNPACK_MSB_FIRST_EN, when defined, SHALL emit beats most-significant first (beat k = bits [width-1-k*beat_width -: beat_width]).
REQ-029 Without FIFO_UNPACK_MSB_FIRST_EN, beats SHALL be emitted least-significant first (beat k = bits [k*beat_width +: beat_width]).

Structure
REQ-030 Shared package fifo_unpack_pkg SHALL hold the state enum (IDLE, SHIFT) and the WORD_COUNT width constant (16).
REQ-031 The block SHALL have no sub-module; FSM, counter, and datapath SHALL be in one module; the bench SHALL connect it to a real FIFO2 instance.

Verification (width=32, beat_width=8, LSB-first unless noted)
REQ-032 Single word: enqueue 0xA1B2C3D4, OUT_READY=1 -> DEQ one cycle; beats D4,C3,B2,A1 on consecutive cycles; OUT_LAST on A1; WORD_COUNT=1; IDLE.
REQ-033 Back-to-back: two words queued, OUT_READY=1 -> 8 consecutive valid beats, no gap; exactly 2 DEQ pulses; WORD_COUNT=2.
REQ-034 Backpressure: OUT_READY low for 3 cycles on beat 2 of 0x11223344 -> OUT_DATA holds 0x22 stable, no DEQ, no count change until accepted.
REQ-035 CLR on beat 1 with another word queued -> IDLE next cycle, no DEQ that cycle; next word starts fresh at beat 0; WORD_COUNT unchanged.
REQ-036 MSB-first build: 0xA1B2C3D4 -> beats A1,B2,C3,D4. Reset mid-word -> outputs 0, WORD_COUNT=0.
REQ-037 Wrap: preload 65535 words -> one more word sets WORD_COUNT=0x0000.
